op_cycle_counter: RTL

OP_CYCLE_COUNTER -- requirements
Module: op_cycle_counter

---
 rtl/op_cycle_counter.sv | 107 ++++++++++
 1 files changed

// File: rtl/op_cycle_counter.sv
// Iteration sequencer for a shared multiply/divide datapath.
// Runs MULT_CYCLES or DIV_CYCLES iterations, then pulses result_rdy once.
module op_cycle_counter #(
    parameter int CNT_W       = 6,
    parameter int MULT_CYCLES = 16,
    parameter int DIV_CYCLES  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             op_is_div,
    output logic             busy,
    output logic             first,
    output logic             last,
    output logic             result_rdy
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > (1 << CNT_W)) begin : g_bad_mult
        $error("MULT_CYCLES must lie in 1..2**CNT_W");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > (1 << CNT_W)) begin : g_bad_div
        $error("DIV_CYCLES must lie in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             op_is_div_q, op_is_div_d;
    logic [CNT_W-1:0] last_cnt;
    logic             start_any;

    assign last_cnt  = op_is_div_q ? DIV_LAST : MULT_LAST;
    assign start_any = start_mult | start_div;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            op_is_div_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_is_div_q <= op_is_div_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_is_div_d = op_is_div_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (start_any) begin
                    state_d     = RUN;
                    op_is_div_d = start_div;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q == last_cnt) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                count_d = '0;
                // Accepting a start here gives back-to-back operation
                if (abort) begin
                    state_d = IDLE;
                end else if (start_any) begin
                    state_d     = RUN;
                    op_is_div_d = start_div;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign count      = count_q;
    assign op_is_div  = op_is_div_q;
    assign busy       = (state_q == RUN);
    assign first      = busy && (count_q == '0);
    assign last       = busy && (count_q == last_cnt);
    assign result_rdy = (state_q == DONE);

endmodule
